// File: rtl/score_keeper_pkg.sv
// Shared encodings and defaults for the score keeper block.
package score_keeper_pkg;

    localparam int DEFAULT_LEVEL_W = 4;
    localparam int DEFAULT_LIVES   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

endpackage

// File: rtl/score_keeper_rise_detect.sv
// Rising-edge detector: pulse is high while d is 1 and was 0 on the previous clock.
module rise_detect (
    input  logic clock,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) prev <= 1'b0;
        else      prev <= d;
    end

    assign pulse = d & ~prev;

endmodule

// File: rtl/score_keeper.sv
// Session score/lives tracker with a per-user best-level table.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int NUM_USERS = 8,
    parameter int ID_W      = 3,
    parameter int LEVEL_W   = DEFAULT_LEVEL_W,
    parameter int LIVES     = DEFAULT_LIVES,
    parameter int WINS_W    = 8
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               auth_bit,
    input  logic               log_out,
    input  logic [ID_W-1:0]    internal_id,
    input  logic               win,
    input  logic               loose,
    input  logic [LEVEL_W-1:0] level_num,
    output logic [1:0]         lives,
    output logic [WINS_W-1:0]  session_wins,
    output logic [LEVEL_W-1:0] best_level,
    output logic               new_record,
    output logic               game_over,
    output logic               playing
);

    state_t              state, state_next;
    logic [ID_W-1:0]     sess_id, sess_id_next;
    logic [1:0]          lives_next;
    logic [WINS_W-1:0]   wins_next;
    logic                tbl_we;
    logic                record_next;
    logic                win_ev, loose_ev;
    logic [LEVEL_W-1:0]  best_tbl [NUM_USERS];

    rise_detect u_win_edge (
        .clock (clock),
        .rst   (rst),
        .d     (win),
        .pulse (win_ev)
    );

    rise_detect u_loose_edge (
        .clock (clock),
        .rst   (rst),
        .d     (loose),
        .pulse (loose_ev)
    );

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next   = state;
        sess_id_next = sess_id;
        lives_next   = lives;
        wins_next    = session_wins;
        tbl_we       = 1'b0;
        record_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (auth_bit && !log_out) begin
                    state_next   = ST_PLAY;
                    sess_id_next = internal_id;
                    lives_next   = 2'(LIVES);
                    wins_next    = '0;
                end
            end
            ST_PLAY: begin
                // log_out wins over any edge event in the same cycle.
                if (log_out) begin
                    state_next = ST_IDLE;
                end else if (loose_ev) begin
                    lives_next = lives - 2'd1;
                    if (lives == 2'd1) state_next = ST_OVER;
                end else if (win_ev) begin
                    if (session_wins != '1) wins_next = session_wins + WINS_W'(1);
                    if (level_num > best_tbl[sess_id]) begin
                        tbl_we      = 1'b1;
                        record_next = 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (log_out) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            sess_id      <= '0;
            lives        <= 2'd0;
            session_wins <= '0;
            new_record   <= 1'b0;
            best_level   <= '0;
        end else begin
            state        <= state_next;
            sess_id      <= sess_id_next;
            lives        <= lives_next;
            session_wins <= wins_next;
            new_record   <= record_next;
            best_level   <= best_tbl[sess_id];
        end
    end

    // NOTE: the table is built from flops, not RAM, so it can be cleared by the async reset.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_USERS; i++) best_tbl[i] <= '0;
        end else if (tbl_we) begin
            best_tbl[sess_id] <= level_num;
        end
    end

    assign playing   = (state == ST_PLAY);
    assign game_over = (state == ST_OVER);

endmodule
